// File: rtl/dma_copy_engine.sv
// rtl/dma_copy_engine.sv - word-by-word memory-to-memory copy engine with range check
module dma_copy_engine #(
   parameter int MEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic [10:0] word_count,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        MemRead,
   output logic        MemWrite,
   output logic [31:0] Address,
   output logic [31:0] WriteData,
   input  logic [31:0] ReadData
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [31:0] address_q, address_d;
   logic [31:0] write_data_q, write_data_d;
   logic [29:0] src_ptr_q, src_ptr_d;
   logic [29:0] dst_ptr_q, dst_ptr_d;
   logic [10:0] rem_q, rem_d;
   logic [31:0] buffer_q, buffer_d;

   // Byte-lane bits of the request addresses carry no meaning for a word copy.
   logic        unused_addr_bits;
   assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

   // Range check: end word of each region, widened so a large base plus count cannot wrap.
   logic [32:0] src_end;
   logic [32:0] dst_end;
   logic        range_bad;
   assign src_end   = {3'b000, src_addr[31:2]} + {22'd0, word_count};
   assign dst_end   = {3'b000, dst_addr[31:2]} + {22'd0, word_count};
   assign range_bad = (src_end > 33'(MEM_WORDS)) || (dst_end > 33'(MEM_WORDS));

   // Next-state and next-output logic: outputs are computed for the state being entered,
   // so each registered strobe lines up with the state it belongs to.
   always_comb begin
      state_d      = state_q;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      err_d        = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      address_d    = 32'd0;
      write_data_d = 32'd0;
      src_ptr_d    = src_ptr_q;
      dst_ptr_d    = dst_ptr_q;
      rem_d        = rem_q;
      buffer_d     = buffer_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               src_ptr_d = src_addr[31:2];
               dst_ptr_d = dst_addr[31:2];
               rem_d     = word_count;
               busy_d    = 1'b1;
               if (range_bad) begin
                  state_d = ERR;
                  err_d   = 1'b1;
               end else if (word_count == 11'd0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d    = READ;
                  mem_read_d = 1'b1;
                  address_d  = {src_addr[31:2], 2'b00};
               end
            end
         end

         READ: begin
            buffer_d     = ReadData;
            state_d      = WRITE;
            busy_d       = 1'b1;
            mem_write_d  = 1'b1;
            address_d    = {dst_ptr_q, 2'b00};
            write_data_d = ReadData;
         end

         WRITE: begin
            src_ptr_d = src_ptr_q + 30'd1;
            dst_ptr_d = dst_ptr_q + 30'd1;
            rem_d     = rem_q - 11'd1;
            busy_d    = 1'b1;
            if (rem_q == 11'd1) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               state_d    = READ;
               mem_read_d = 1'b1;
               address_d  = {src_ptr_q + 30'd1, 2'b00};
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         ERR: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, pointer and registered-output flops; reset clears everything at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         address_q    <= 32'd0;
         write_data_q <= 32'd0;
         src_ptr_q    <= 30'd0;
         dst_ptr_q    <= 30'd0;
         rem_q        <= 11'd0;
         buffer_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
         src_ptr_q    <= src_ptr_d;
         dst_ptr_q    <= dst_ptr_d;
         rem_q        <= rem_d;
         buffer_q     <= buffer_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign MemRead   = mem_read_q;
   assign MemWrite  = mem_write_q;
   assign Address   = address_q;
   assign WriteData = write_data_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb/tb_dma_copy_engine.sv - directed and randomized checks of dma_copy_engine against a word-array model
module tb_dma_copy_engine;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [10:0] word_count;
   logic        busy;
   logic        done;
   logic        err;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [31:0] ReadData;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];

   dma_copy_engine #(.MEM_WORDS(1024)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .Address    (Address),
      .WriteData  (WriteData),
      .ReadData   (ReadData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Attached data memory: combinational read, write on rising edge.
   assign ReadData = MemRead ? mem[Address[11:2]] : 32'd0;
   always @(posedge clk) begin
      if (MemWrite) mem[Address[11:2]] <= WriteData;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Invariants sampled every cycle away from the active edge.
   always @(negedge clk) begin
      chk("strobe_exclusive", {31'd0, MemRead & MemWrite}, 32'd0);
      chk("addr_aligned", {30'd0, Address[1:0]}, 32'd0);
   end

   task automatic chk_mem_image(input string tag);
      int mism = 0;
      for (int k = 0; k < 1024; k++) if (mem[k] !== ref_mem[k]) mism++;
      chk(tag, 32'(mism), 32'd0);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
      chk({tag, "_rd"}, {31'd0, MemRead}, 32'd0);
      chk({tag, "_wr"}, {31'd0, MemWrite}, 32'd0);
      chk({tag, "_addr"}, Address, 32'd0);
      chk({tag, "_wdata"}, WriteData, 32'd0);
   endtask

   // One request: the model decides accept/reject from the range rule, then expects
   // READ/WRITE pairs in ascending order, copying through ref_mem word by word.
   task automatic do_copy(input logic [31:0] src_b, input logic [31:0] dst_b, input int cnt,
                          input bit mid_start, input int abort_after);
      longint sw = longint'(src_b >> 2);
      longint dw = longint'(dst_b >> 2);
      bit exp_err = ((sw + cnt) > 1024) || ((dw + cnt) > 1024);
      logic [31:0] exp_word;

      @(negedge clk);
      src_addr = src_b; dst_addr = dst_b; word_count = 11'(cnt); start = 1'b1;
      @(negedge clk);
      start = 1'b0; src_addr = $urandom; dst_addr = $urandom; word_count = 11'($urandom);

      if (exp_err) begin
         chk("err_pulse", {31'd0, err}, 32'd1);
         chk("err_busy", {31'd0, busy}, 32'd1);
         chk("err_no_rd", {31'd0, MemRead}, 32'd0);
         chk("err_no_wr", {31'd0, MemWrite}, 32'd0);
         chk("err_no_done", {31'd0, done}, 32'd0);
         @(negedge clk);
         chk("err_once", {31'd0, err}, 32'd0);
         chk("err_busy_off", {31'd0, busy}, 32'd0);
         chk_mem_image("err_mem_unchanged");
         return;
      end

      for (int i = 0; i < cnt; i++) begin
         if (i == abort_after) begin
            rst_n = 1'b0;
            #1;
            chk_idle_outputs("abort");
            @(negedge clk);
            rst_n = 1'b1;
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               chk("abort_no_done", {31'd0, done}, 32'd0);
               chk("abort_idle_busy", {31'd0, busy}, 32'd0);
            end
            chk_mem_image("abort_mem");
            return;
         end
         exp_word = ref_mem[sw + i];
         chk("rd_strobe", {31'd0, MemRead}, 32'd1);
         chk("rd_no_wr", {31'd0, MemWrite}, 32'd0);
         chk("rd_addr", Address, 32'((sw + i) * 4));
         chk("rd_busy", {31'd0, busy}, 32'd1);
         chk("rd_no_done", {31'd0, done}, 32'd0);
         if (mid_start && i == 1) begin
            src_addr = 32'h0000_0800; dst_addr = 32'h0000_0C00; word_count = 11'd3; start = 1'b1;
         end
         @(negedge clk);
         start = 1'b0;
         chk("wr_strobe", {31'd0, MemWrite}, 32'd1);
         chk("wr_no_rd", {31'd0, MemRead}, 32'd0);
         chk("wr_addr", Address, 32'((dw + i) * 4));
         chk("wr_data", WriteData, exp_word);
         chk("wr_busy", {31'd0, busy}, 32'd1);
         ref_mem[dw + i] = exp_word;
         @(negedge clk);
      end

      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("done_busy", {31'd0, busy}, 32'd1);
      chk("done_no_rd", {31'd0, MemRead}, 32'd0);
      chk("done_no_wr", {31'd0, MemWrite}, 32'd0);
      chk("done_no_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      chk("done_once", {31'd0, done}, 32'd0);
      chk("done_busy_off", {31'd0, busy}, 32'd0);
      chk_mem_image("copy_mem");
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0; word_count = 11'd0;
      for (int k = 0; k < 1024; k++) begin
         mem[k] = $urandom;
         ref_mem[k] = mem[k];
      end
      mem[0] = 32'hAAAA_0001; mem[1] = 32'hBBBB_0002; mem[2] = 32'hCCCC_0003; mem[3] = 32'hDDDD_0004;
      for (int k = 0; k < 4; k++) ref_mem[k] = mem[k];

      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle_outputs("post_reset_idle");

      // Four-word copy with known contents, then count zero.
      do_copy(32'h0, 32'h40, 4, 1'b0, -1);
      chk("copy_dst0", mem[16], 32'hAAAA_0001);
      chk("copy_dst3", mem[19], 32'hDDDD_0004);
      chk("copy_src_kept", mem[0], 32'hAAAA_0001);
      do_copy(32'h100, 32'h200, 0, 1'b0, -1);

      // Range boundaries at the top of memory and a huge base address.
      do_copy(32'hFFC, 32'h0, 2, 1'b0, -1);
      do_copy(32'h0, 32'hFFC, 2, 1'b0, -1);
      do_copy(32'hFFC, 32'h10, 1, 1'b0, -1);
      do_copy(32'hFFFF_FFFC, 32'h0, 1, 1'b0, -1);
      do_copy(32'h0, 32'h0, 1100, 1'b0, -1);
      do_copy(32'h0, 32'h0, 1024, 1'b0, -1);

      // Unaligned bases with an ignored mid-copy start, and an overlapping forward copy.
      do_copy(32'h3, 32'h21, 5, 1'b1, -1);
      do_copy(32'h80, 32'h84, 6, 1'b0, -1);

      // Reset after three of six words, then a clean rerun.
      do_copy(32'h200, 32'h300, 6, 1'b0, 3);
      do_copy(32'h200, 32'h300, 6, 1'b0, -1);

      // Randomized requests, some landing past the end of memory.
      for (int n = 0; n < 25; n++) begin
         do_copy(32'($urandom_range(0, 1023) * 4 + $urandom_range(0, 3)),
                 32'($urandom_range(0, 1023) * 4 + $urandom_range(0, 3)),
                 int'($urandom_range(0, 24)), 1'($urandom_range(0, 1)), -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dma_copy_engine.md
DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 Parameter MEM_WORDS, default 1024, is the number of 32-bit words in the attached data memory.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 src_addr  input  32  byte address of first source word; bits [1:0] ignored.
REQ-006 dst_addr  input  32  byte address of first destination word; bits [1:0] ignored.
REQ-007 word_count  input  11  number of words to copy, 0..1024.
REQ-008 busy  output  1  high from the cycle after accepted start until return to IDLE.
REQ-009 done  output  1  one-cycle pulse on successful completion.
REQ-010 err  output  1  one-cycle pulse when a request is rejected for range.
REQ-011 MemRead  output  1  read strobe to data memory.
REQ-012 MemWrite  output  1  write strobe to data memory; memory writes on rising clk edge.
REQ-013 Address  output  32  word-aligned byte address to memory; bits [1:0] always 0.
REQ-014 WriteData  output  32  data to memory.
REQ-015 ReadData  input  32  combinational read data from memory, valid in the same cycle as MemRead.

Function
REQ-016 States SHALL be IDLE, READ, WRITE, DONE, ERR.
REQ-017 IDLE: start=1 SHALL latch src_addr[31:2], dst_addr[31:2] and word_count into internal pointers/counter.
REQ-018 In IDLE with start=1: if src_word+word_count > MEM_WORDS or dst_word+word_count > MEM_WORDS (computed without overflow, at least 33 bits), next state SHALL be ERR; else if word_count=0, next state DONE; else READ.
REQ-019 READ: MemRead=1, Address={src_ptr,2'b00}; on the clock edge ReadData SHALL be captured into a 32-bit buffer; next state WRITE.
REQ-020 WRITE: MemWrite=1, Address={dst_ptr,2'b00}, WriteData=buffer; on the edge src_ptr and dst_ptr SHALL increment by 1 word, remaining SHALL decrement by 1.
REQ-021 WRITE with remaining=1 SHALL go to DONE; otherwise it SHALL go to READ.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE. ERR: err=1 for exactly one cycle, then IDLE; no memory strobe in ERR.
REQ-023 MemRead and MemWrite SHALL never be high in the same cycle; both SHALL be 0 in IDLE, DONE and ERR; Address and WriteData SHALL be 0 when the corresponding strobe is low.
REQ-024 Copy of N>0 words SHALL take exactly 2N cycles in READ/WRITE, followed by one DONE cycle; busy SHALL be high in READ, WRITE, DONE and ERR.
REQ-025 start while not IDLE SHALL be ignored; inputs src_addr/dst_addr/word_count SHALL not affect an in-progress copy.
REQ-026 Copy SHALL proceed in ascending address order; overlapping regions are copied word by word in that order with no correction.
REQ-027 word_count values above 1024 SHALL be treated by the range check (REQ-018) and rejected via ERR.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, err=0, MemRead=0, MemWrite=0, Address=0, WriteData=0, and clear pointers, counter and buffer.
REQ-029 Reset asserted mid-copy SHALL abort the copy; any write already clocked into memory remains; no done pulse is produced.
REQ-030 After rst_n deasserts, the first rising edge SHALL evaluate from IDLE.

Verification
REQ-031 Preload mem[0..3]=A,B,C,D; start src=0x0, dst=0x40, count=4 -> 8 busy copy cycles with alternating READ/WRITE strobes, done pulse in cycle 9, mem[16..19]=A,B,C,D, mem[0..3] unchanged.
REQ-032 start with count=0 -> no MemRead/MemWrite, done pulse the cycle after start, busy high for that one cycle only.
REQ-033 start src=0xFFC (word 1023), count=2 -> err pulse one cycle after start, no memory strobes, memory unchanged; same for dst=0xFFC, count=2; src=0xFFC, count=1 copies successfully.
REQ-034 start with src=0x3, dst=0x21 -> Address values 0x0, 0x20 (low bits dropped); second start issued mid-copy -> ignored, first copy completes normally.
REQ-035 Assert rst_n=0 after 3 of 6 words copied -> all outputs 0 immediately, destination words 3..5 unchanged, no done; new start after release completes normally.
REQ-036 Throughout every test, assert MemRead&MemWrite never 1 together and Address[1:0] always 0.
